// File: rtl/mul_unsigned_seq_if.sv
// Operand/result handshake bundle for the sequential unsigned multiplier.
// The master drives operands and result acceptance; the slave is the multiplier.
interface mul_unsigned_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/mul_unsigned_seq.sv
// Iterative radix-2 shift-add unsigned multiplier: one adder, WIDTH-cycle latency.
// Optional MUL_SEQ_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module mul_unsigned_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_unsigned_seq_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    z_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    mcand_d;
  logic [WIDTH-1:0] mplr_d;
  logic [CNT_W-1:0] cnt_d;
  logic             finish;

  // One CALC step; acc cannot overflow since the final sum is bounded by a*b.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    acc_d   = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d = mcand_q << 1;
    mplr_d  = mplr_q >> 1;
    cnt_d   = cnt_q + CNT_W'(1);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    finish  = (cnt_q == LAST_CNT) || (mplr_d == '0);
`else
    finish  = (cnt_q == LAST_CNT);
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: all datapath registers are reset so an aborted product can never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand_q    <= {{WIDTH{1'b0}}, bus.a};
            mplr_q     <= bus.b;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_d;
          mplr_q  <= mplr_d;
          cnt_q   <= cnt_d;
          if (finish) begin
            z_q         <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // z_q is left untouched so the result stays readable until the next load.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;

endmodule

// File: tb/tb_mul_unsigned_seq.sv
// Scoreboard bench for mul_unsigned_seq: directed corner cases plus a random sweep
// with random back-pressure, checked against an arithmetic reference model.
module tb_mul_unsigned_seq;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] prod;
    int            lat;
    int            acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  mul_unsigned_seq_if #(.WIDTH(W)) bus ();

  mul_unsigned_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks;
  int   n_fail;
  int   cyc;
  int   n_acc;
  int   n_out;
  int   ready_mode;   // 0 = hold low, 1 = hold high, 2 = random
  exp_t sb_q[$];

  logic          ov_prev;
  logic          hs_prev;
  logic [PW-1:0] z_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [PW-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return PW'(p);
  endfunction

  function automatic int model_lat(input logic [W-1:0] b);
    int lat;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    lat = 1;
    for (int i = 0; i < W; i++)
      if (b[i]) lat = i + 1;
`else
    lat = W;
`endif
    return lat;
  endfunction

  // Output ready driver; the only process that writes out_ready.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: records accepts into the scoreboard and checks every presented result.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) check("pulse_drop", 64'(bus.out_valid), 64'd0);
      if (bus.out_valid) begin
        check("busy_in_ready", 64'(bus.in_ready), 64'd0);
        if (!ov_prev) begin
          if (sb_q.size() == 0) fail_now("unexpected_result");
          else check("latency", 64'(cyc - sb_q[0].acc_cyc - 1), 64'(sb_q[0].lat));
        end else begin
          check("z_hold", 64'(bus.z), 64'(z_prev));
        end
        if (bus.out_ready) begin
          if (sb_q.size() == 0) begin
            fail_now("result_without_accept");
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("product", 64'(bus.z), 64'(e.prod));
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.prod    = model_prod(bus.a, bus.b);
        e.lat     = model_lat(bus.b);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        n_acc++;
      end
      ov_prev = bus.out_valid;
      z_prev  = bus.z;
      hs_prev = bus.out_valid && bus.out_ready;
    end
  end

  // Presents one operand pair and returns just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && bus.in_ready) done = 1'b1;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; n_acc = 0; n_out = 0;
    ready_mode = 1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_z", 64'(bus.z), 64'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-scale operands with out_ready held high.
    send(8'd255, 8'd255);
    wait_drain();
    check("t1_z", 64'(bus.z), 64'd65025);

    // Zero operands.
    send(8'd13, 8'd0);
    wait_drain();
    check("t2_z_b0", 64'(bus.z), 64'd0);
    send(8'd0, 8'd200);
    wait_drain();
    check("t2_z_a0", 64'(bus.z), 64'd0);

    // Back-pressure: result must be held while out_ready is low.
    @(posedge clk); #1;
    ready_mode = 0;
    @(posedge clk); #1;
    send(8'd7, 8'd9);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen = 1'b1;
      end
      if (!seen) fail_now("t3_valid_timeout");
    end
    repeat (5) @(negedge clk);
    check("t3_z_held", 64'(bus.z), 64'd63);
    check("t3_valid_held", 64'(bus.out_valid), 64'd1);
    ready_mode = 1;
    @(posedge clk);
    @(posedge clk); #2;
    check("t3_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("t3_idle_out_valid", 64'(bus.out_valid), 64'd0);
    wait_drain();

    // in_valid held during CALC with new operands: must wait for the handshake.
    ready_mode = 2;
    send(8'd11, 8'd12);
    send(8'd200, 8'd3);
    wait_drain();
    ready_mode = 1;

    // Reset in the middle of CALC.
    send(8'd100, 8'd50);
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_z", 64'(bus.z), 64'd0);
    check("t5_in_ready", 64'(bus.in_ready), 64'd1);
    n_acc = n_acc - 1;   // the aborted transaction never produces a result
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd3, 8'd4);
    wait_drain();
    check("t5_next_z", 64'(bus.z), 64'd12);

    // Random sweep with random back-pressure and idle gaps.
    ready_mode = 2;
    for (int n = 0; n < 1500; n++) begin
      logic [W-1:0] ra, rb;
      case ($urandom_range(0, 7))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = W'(1) << $urandom_range(0, W - 1);
        default: rb = W'($urandom);
      endcase
      send(ra, rb);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    wait_drain();

    check("no_lost_results", 64'(n_out), 64'(n_acc));
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
